// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
// Holds the FSM state encoding, ALU operation classes, ALUControl codes,
// opcode constants, and the select encodings driven into the datapath muxes.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_op_decoder.sv
// ALU decoder: maps the FSM's ALU operation class plus instruction fields to
// the 3-bit ALUControl code.
// Ports: alu_op (class), funct3, op5 (Instr[5]), funct7b5 (Instr[30])
//        -> alu_control, funct_illegal (funct3 has no supported ALU function).
import multicycle_controller_pkg::*;

module multicycle_controller_alu_op_decoder (
    input  aluop_t     alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        // Independent of alu_op so DECODE (which runs an add) can still flag it.
        funct_illegal = !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
        alu_control   = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    // Only R-type (op5=1) can select sub; addi ignores Instr[30].
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RV32I core.
// Moore FSM sequencing each instruction; all outputs decode combinationally
// from the state register and the latched instruction fields.
// Inputs : clk, reset (async, active-low), op, funct3, funct7b5, Zero.
// Outputs: PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
//          ALUSrcA, ALUSrcB, ImmSrc, RegWrite, Illegal, State (debug).
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4
// DECODE   | read registers, branch target into ALUOut, dispatch on op
// MEMADR   | compute load/store address
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to register file
// MEMWRITE | write data memory at ALUOut
// EXECUTER | R-type ALU operation
// EXECUTEI | I-type ALU operation
// ALUWB    | write ALUOut to register file
// BRANCH   | compare operands, conditionally load PC from ALUOut
// JAL      | PC <= target, ALU computes OldPC+4 for the link register
import multicycle_controller_pkg::*;

module multicycle_controller #(
    parameter bit BNE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t state, state_next;
    aluop_t alu_op;
    logic   pc_update, branch, mem_write, ir_write, reg_write;
    logic   funct_illegal, branch_ok, branch_taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    assign branch_ok    = (funct3 == 3'b000) || (BNE_EN && (funct3 == 3'b001));
    assign branch_taken = (funct3 == 3'b000) ? Zero
                                             : (BNE_EN && (funct3 == 3'b001) && !Zero);

    always_comb begin
        state_next = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        AdrSrc     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        ResultSrc  = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_WD;
        Illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                pc_update  = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE: if (funct_illegal) Illegal = 1'b1;
                              else state_next = S_EXECUTER;
                    OP_ITYPE: if (funct_illegal) Illegal = 1'b1;
                              else state_next = S_EXECUTEI;
                    OP_BRANCH: if (branch_ok) state_next = S_BRANCH;
                               else Illegal = 1'b1;
                    OP_JAL:   state_next = S_JAL;
                    default:  Illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_A;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_A;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    multicycle_controller_alu_op_decoder u_alu_op_decoder (
        .alu_op       (alu_op),
        .funct3       (funct3),
        .op5          (op[5]),
        .funct7b5     (funct7b5),
        .alu_control  (ALUControl),
        .funct_illegal(funct_illegal)
    );

    // Architectural write enables are held off for the whole reset interval.
    assign PCWrite  = reset & (pc_update | (branch & branch_taken));
    assign IRWrite  = reset & ir_write;
    assign RegWrite = reset & reg_write;
    assign MemWrite = reset & mem_write;
    assign State    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                           MW = 4'd5, XR = 4'd6, XI = 4'd7, AWB = 4'd8, BR = 4'd9, JL = 4'd10;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;

    multicycle_controller #(.BNE_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        #2;
        checks++; if (State !== F) begin errors++; $display("FAIL rst_state: got %0d want %0d", State, F); end
        checks++; if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin errors++;
            $display("FAIL rst_enables: got %b want 0000", {PCWrite, IRWrite, RegWrite, MemWrite}); end
        step(); step();
        checks++; if (State !== F) begin errors++; $display("FAIL rst_hold: got %0d want %0d", State, F); end
        @(negedge clk); reset = 1'b1; #1;
        checks++; if ({IRWrite, PCWrite, ALUSrcB} !== 4'b1110) begin errors++;
            $display("FAIL rst_release1: got %b want 1110", {IRWrite, PCWrite, ALUSrcB}); end
        step();
        checks++; if (State !== D) begin errors++; $display("FAIL rst_decode: got %0d want %0d", State, D); end
        step();
        checks++; if (State !== XR) begin errors++; $display("FAIL rst_execr: got %0d want %0d", State, XR); end
        reset = 1'b0; #1;
        checks++; if (State !== F) begin errors++; $display("FAIL rst_mid_state: got %0d want %0d", State, F); end
        checks++; if ({PCWrite, IRWrite, RegWrite, MemWrite, ALUSrcB} !== 6'b000010) begin errors++;
            $display("FAIL rst_mid_out: got %b want 000010", {PCWrite, IRWrite, RegWrite, MemWrite, ALUSrcB}); end
        step();
        checks++; if ({State, RegWrite, IRWrite} !== {F, 2'b00}) begin errors++;
            $display("FAIL rst_mid_hold: got %b want %b", {State, RegWrite, IRWrite}, {F, 2'b00}); end
        @(negedge clk); reset = 1'b1; #1;
        checks++; if ({IRWrite, PCWrite, ALUSrcB} !== 4'b1110) begin errors++;
            $display("FAIL rst_release2: got %b want 1110", {IRWrite, PCWrite, ALUSrcB}); end
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [5];
        exp_st = '{F, D, MA, MR, MWB};
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (State !== exp_st[i]) begin errors++;
                $display("FAIL lw_state[%0d]: got %0d want %0d", i, State, exp_st[i]); end
            checks++; if (RegWrite !== (i == 4)) begin errors++;
                $display("FAIL lw_regwrite[%0d]: got %b want %b", i, RegWrite, (i == 4)); end
            checks++; if ({MemWrite, ImmSrc} !== 3'b000) begin errors++;
                $display("FAIL lw_memw_imm[%0d]: got %b want 000", i, {MemWrite, ImmSrc}); end
            if (i == 0) begin
                checks++; if ({IRWrite, PCWrite, ALUSrcB, ResultSrc} !== 6'b111010) begin errors++;
                    $display("FAIL lw_fetch: got %b want 111010", {IRWrite, PCWrite, ALUSrcB, ResultSrc}); end
            end
            if (i == 3) begin
                checks++; if ({AdrSrc, ResultSrc} !== 3'b100) begin errors++;
                    $display("FAIL lw_memread: got %b want 100", {AdrSrc, ResultSrc}); end
            end
            if (i == 4) begin
                checks++; if (ResultSrc !== 2'b01) begin errors++;
                    $display("FAIL lw_resultsrc: got %b want 01", ResultSrc); end
            end
            step();
        end
        checks++; if (State !== F) begin errors++; $display("FAIL lw_len: got %0d want %0d", State, F); end
    endtask

    task automatic test_alu_ops();
        logic [6:0] t_op [6];
        logic [2:0] t_f3 [6];
        logic       t_f7 [6];
        logic [2:0] t_ctl[6];
        t_op  = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011, 7'b0110011};
        t_f3  = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b110, 3'b010};
        t_f7  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        t_ctl = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b011, 3'b101};
        for (int i = 0; i < 6; i++) begin
            op = t_op[i]; funct3 = t_f3[i]; funct7b5 = t_f7[i]; #1;
            step();
            checks++; if ({State, Illegal} !== {D, 1'b0}) begin errors++;
                $display("FAIL alu_decode[%0d]: got %b want %b", i, {State, Illegal}, {D, 1'b0}); end
            step();
            checks++; if (State !== (t_op[i][5] ? XR : XI)) begin errors++;
                $display("FAIL alu_exec_state[%0d]: got %0d", i, State); end
            checks++; if (ALUControl !== t_ctl[i]) begin errors++;
                $display("FAIL alu_control[%0d]: got %b want %b", i, ALUControl, t_ctl[i]); end
            checks++; if ({ALUSrcA, ALUSrcB} !== {2'b10, (t_op[i][5] ? 2'b00 : 2'b01)}) begin errors++;
                $display("FAIL alu_srcs[%0d]: got %b", i, {ALUSrcA, ALUSrcB}); end
            step();
            checks++; if ({State, RegWrite, ResultSrc} !== {AWB, 3'b100}) begin errors++;
                $display("FAIL alu_wb[%0d]: got %b want %b", i, {State, RegWrite, ResultSrc}, {AWB, 3'b100}); end
            step();
            checks++; if (State !== F) begin errors++; $display("FAIL alu_len[%0d]: got %0d want 0", i, State); end
        end
    endtask

    task automatic test_branch();
        logic [2:0] t_f3 [4];
        logic       t_z  [4];
        logic       t_pc [4];
        t_f3 = '{3'b000, 3'b000, 3'b001, 3'b001};
        t_z  = '{1'b1, 1'b0, 1'b1, 1'b0};
        t_pc = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            op = 7'b1100011; funct3 = t_f3[i]; funct7b5 = 1'b0; Zero = t_z[i]; #1;
            checks++; if (ImmSrc !== 2'b10) begin errors++;
                $display("FAIL br_immsrc[%0d]: got %b want 10", i, ImmSrc); end
            step(); step();
            checks++; if (State !== BR) begin errors++;
                $display("FAIL br_state[%0d]: got %0d want %0d", i, State, BR); end
            checks++; if (PCWrite !== t_pc[i]) begin errors++;
                $display("FAIL br_pcwrite[%0d]: got %b want %b", i, PCWrite, t_pc[i]); end
            checks++; if ({ALUControl, RegWrite} !== 4'b0010) begin errors++;
                $display("FAIL br_alu[%0d]: got %b want 0010", i, {ALUControl, RegWrite}); end
            step();
            checks++; if (State !== F) begin errors++; $display("FAIL br_len[%0d]: got %0d want 0", i, State); end
        end
        Zero = 1'b0;
    endtask

    task automatic test_jal();
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; #1;
        checks++; if (ImmSrc !== 2'b11) begin errors++; $display("FAIL jal_imm_fetch: got %b want 11", ImmSrc); end
        step(); step();
        checks++; if (State !== JL) begin errors++; $display("FAIL jal_state: got %0d want %0d", State, JL); end
        checks++; if ({PCWrite, ALUSrcA, ALUSrcB, ImmSrc, RegWrite} !== 8'b1_01_10_11_0) begin errors++;
            $display("FAIL jal_out: got %b want 10110110", {PCWrite, ALUSrcA, ALUSrcB, ImmSrc, RegWrite}); end
        step();
        checks++; if ({State, RegWrite, ImmSrc} !== {AWB, 3'b111}) begin errors++;
            $display("FAIL jal_wb: got %b want %b", {State, RegWrite, ImmSrc}, {AWB, 3'b111}); end
        step();
        checks++; if (State !== F) begin errors++; $display("FAIL jal_len: got %0d want 0", State); end
    endtask

    task automatic test_illegal();
        logic [6:0] t_op [3];
        logic [2:0] t_f3 [3];
        t_op = '{7'b1111111, 7'b0110011, 7'b1100011};
        t_f3 = '{3'b000, 3'b001, 3'b100};
        for (int i = 0; i < 3; i++) begin
            op = t_op[i]; funct3 = t_f3[i]; funct7b5 = 1'b0; #1;
            checks++; if (Illegal !== 1'b0) begin errors++; $display("FAIL ill_fetch[%0d]: got %b want 0", i, Illegal); end
            step();
            checks++; if ({State, Illegal, RegWrite, MemWrite} !== {D, 3'b100}) begin errors++;
                $display("FAIL ill_decode[%0d]: got %b want %b", i, {State, Illegal, RegWrite, MemWrite}, {D, 3'b100}); end
            step();
            checks++; if ({State, Illegal} !== {F, 1'b0}) begin errors++;
                $display("FAIL ill_next[%0d]: got %b want %b", i, {State, Illegal}, {F, 1'b0}); end
        end
    endtask

    task automatic test_sw();
        logic [3:0] exp_st [4];
        exp_st = '{F, D, MA, MW};
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (State !== exp_st[i]) begin errors++;
                $display("FAIL sw_state[%0d]: got %0d want %0d", i, State, exp_st[i]); end
            checks++; if ({MemWrite, RegWrite, ImmSrc} !== {(i == 3), 3'b001}) begin errors++;
                $display("FAIL sw_out[%0d]: got %b want %b", i, {MemWrite, RegWrite, ImmSrc}, {(i == 3), 3'b001}); end
            if (i == 3) begin
                checks++; if ({AdrSrc, ResultSrc} !== 3'b100) begin errors++;
                    $display("FAIL sw_addr: got %b want 100", {AdrSrc, ResultSrc}); end
            end
            step();
        end
        checks++; if (State !== F) begin errors++; $display("FAIL sw_len: got %0d want 0", State); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_alu_ops();
        test_branch();
        test_jal();
        test_illegal();
        test_sw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
